// File: rtl/vmem_stage_if.sv
// vmem_stage_if: beat-level synchronous data-memory bus between the memory stage and data memory.
interface vmem_stage_if #(
  parameter int A = 32,
  parameter int N = 32
);
  logic         mem_req;
  logic         mem_we;
  logic [A-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_ack;
  logic [N-1:0] mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/vmem_stage.sv
// vmem_stage: memory-access stage turning scalar/vector loads and stores into N-bit bus beats.
module vmem_stage #(
  parameter int V = 128,
  parameter int N = 32,
  parameter int A = 32,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         memrd_E,
  input  logic         memwr_E,
  input  logic         vec_E,
  input  logic         regw_E,
  input  logic         regmem_E,
  input  logic [M-1:0] regScr_E,
  input  logic [V-1:0] ALUrslt_E,
  input  logic [V-1:0] wdata_E,
  input  logic         stall_W,
  output logic         stall_M,
  output logic         regw_M,
  output logic         regmem_M,
  output logic [M-1:0] regScr_M,
  output logic [V-1:0] ALUrslt_M,
  output logic [V-1:0] readdata_M,
  vmem_stage_if.master mem
);
  localparam int NB = V / N;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [BW-1:0] beat, beat_n;
  logic op, last, load_ack;
  assign op = memrd_E | memwr_E;
  assign last = beat == (vec_E ? BW'(NB - 1) : BW'(0));
  assign load_ack = state == ACCESS && mem.mem_ack && memrd_E && !memwr_E;
  assign mem.mem_addr = {ALUrslt_E[A-1:2], 2'b00} + A'(beat) * A'(N / 8);
  assign mem.mem_wdata = wdata_E[N * beat +: N];
  assign regw_M = regw_E & ~stall_M;
  assign regmem_M = regmem_E;
  assign regScr_M = regScr_E;
  assign ALUrslt_M = ALUrslt_E;
  // While reset is held the stage looks idle and unstalled regardless of inputs.
  always_comb begin
    state_n = state;
    beat_n = beat;
    stall_M = rst & stall_W;
    mem.mem_req = 1'b0;
    mem.mem_we = 1'b0;
    if (rst)
      case (state)
        IDLE: begin
          state_n = op ? ACCESS : IDLE;
          beat_n = '0;
          stall_M = op | stall_W;
        end
        ACCESS: begin
          stall_M = 1'b1;
          mem.mem_req = 1'b1;
          mem.mem_we = memwr_E;
          state_n = mem.mem_ack && last ? DONE : ACCESS;
          beat_n = mem.mem_ack ? (last ? '0 : beat + 1'b1) : beat;
        end
        DONE: state_n = stall_W ? DONE : IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      beat <= '0;
      readdata_M <= '0;
    end else begin
      state <= state_n;
      beat <= beat_n;
      if (load_ack && vec_E) readdata_M[N * beat +: N] <= mem.mem_rdata;
      else if (load_ack) readdata_M <= V'(mem.mem_rdata);
    end
endmodule

// File: tb/tb_vmem_stage.sv
// tb_vmem_stage: randomized scoreboard bench with a word-level memory model and a bus responder.
module tb_vmem_stage;
  logic clk, rst;
  logic memrd_E, memwr_E, vec_E, regw_E, regmem_E, stall_W;
  logic [3:0] regScr_E;
  logic [127:0] ALUrslt_E, wdata_E;
  logic stall_M, regw_M, regmem_M;
  logic [3:0] regScr_M;
  logic [127:0] ALUrslt_M, readdata_M;
  vmem_stage_if bus();
  vmem_stage dut (
    .clk(clk), .rst(rst), .memrd_E(memrd_E), .memwr_E(memwr_E), .vec_E(vec_E),
    .regw_E(regw_E), .regmem_E(regmem_E), .regScr_E(regScr_E), .ALUrslt_E(ALUrslt_E),
    .wdata_E(wdata_E), .stall_W(stall_W), .stall_M(stall_M), .regw_M(regw_M),
    .regmem_M(regmem_M), .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M),
    .readdata_M(readdata_M), .mem(bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr, vec, regw, regmem;
    logic [3:0] scr;
    logic [127:0] alu, wd;
    logic [3:0][3:0] waits;
    int dstall;
  } ins_t;
  typedef struct {
    logic [31:0] addr;
    logic we;
    logic [31:0] wdata;
    int waits;
    logic last;
    int dstall;
  } beat_t;
  typedef struct {
    logic regw, regmem;
    logic [3:0] scr;
    logic [127:0] alu, rd;
    int stalls;
  } ret_t;

  beat_t bq[$];
  ret_t ret_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] bus_mem[logic [31:0]];
  logic [127:0] exp_rd;
  int n_vec = 0, errs = 0, done_pending = 0;
  logic valid, auto, bail, man_ack;
  logic [31:0] man_rdata;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction
  function automatic logic [31:0] rd_bus(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : seed_word(a);
  endfunction

  function automatic ins_t mk(input logic rd, input logic wr, input logic vec, input logic [31:0] addr,
                              input logic [127:0] wd, input logic [15:0] waits, input int dstall);
    ins_t t;
    t.rd = rd; t.wr = wr; t.vec = vec;
    t.regw = 1'b1; t.regmem = rd;
    t.scr = 4'($urandom);
    t.alu = {$urandom, $urandom, $urandom, addr};
    t.wd = wd; t.waits = waits; t.dstall = dstall;
    return t;
  endfunction

  // Reference model: expected beats and retirement derived from the instruction alone.
  task automatic issue(input ins_t t);
    beat_t b;
    ret_t r;
    logic [127:0] nrd;
    logic [31:0] base, a;
    logic s;
    int nb, cyc;
    if (bail) return;
    nrd = '0;
    nb = t.vec ? 4 : 1;
    base = {t.alu[31:2], 2'b00};
    r.stalls = 0;
    if (t.rd | t.wr) begin
      for (int i = 0; i < nb; i++) begin
        a = base + 32'(4 * i);
        b.addr = a; b.we = t.wr; b.wdata = t.wd[32*i +: 32];
        b.waits = int'(t.waits[i]); b.last = (i == nb - 1); b.dstall = t.dstall;
        bq.push_back(b);
        if (t.wr) ref_mem[a] = t.wd[32*i +: 32];
        else nrd[32*i +: 32] = rd_ref(a);
        r.stalls += 1 + b.waits;
      end
      r.stalls += 1 + t.dstall;
      if (!t.wr) exp_rd = nrd;
    end
    r.regw = t.regw; r.regmem = t.regmem; r.scr = t.scr; r.alu = t.alu; r.rd = exp_rd;
    ret_q.push_back(r);
    memrd_E = t.rd; memwr_E = t.wr; vec_E = t.vec; regw_E = t.regw; regmem_E = t.regmem;
    regScr_E = t.scr; ALUrslt_E = t.alu; wdata_E = t.wd;
    valid = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      s = stall_M;
      @(posedge clk);
      #1;
      cyc++;
    end while (s && cyc < 100);
    valid = 0;
    if (s) begin
      n_vec++; errs++; bail = 1;
      $display("FAIL timeout: stall_M still 1 after %0d cycles, required release", cyc);
    end
  endtask

  // Bus responder and beat monitor: inserts planned wait states and checks every requested beat.
  initial begin
    beat_t h;
    int w = 0;
    bus.mem_ack = 0;
    bus.mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (!auto) begin
        bus.mem_ack = man_ack;
        bus.mem_rdata = man_rdata;
      end else if (!bus.mem_req) bus.mem_ack = 0;
      else if (bq.size() == 0) begin
        n_vec++; errs++; bus.mem_ack = 0;
        $display("FAIL beat: unexpected request addr %h, required none", bus.mem_addr);
      end else begin
        h = bq[0];
        chk("beat_addr", bus.mem_addr, h.addr);
        chk("beat_we", bus.mem_we, h.we);
        if (h.we) chk("beat_wdata", bus.mem_wdata, h.wdata);
        if (w < h.waits) begin
          bus.mem_ack = 0;
          w++;
        end else begin
          bus.mem_ack = 1;
          w = 0;
          bus.mem_rdata = rd_bus(bus.mem_addr);
          if (bus.mem_we) bus_mem[bus.mem_addr] = bus.mem_wdata;
          if (h.last) done_pending = h.dstall;
          void'(bq.pop_front());
        end
      end
    end
  end

  // Downstream stall: held for the planned number of cycles after the last beat completes.
  initial begin
    stall_W = 0;
    forever begin
      @(posedge clk);
      #1;
      if (done_pending > 0) begin
        stall_W = 1;
        done_pending--;
      end else stall_W = 0;
    end
  end

  // Retirement monitor: each unstalled cycle with an instruction present retires one entry.
  initial begin
    ret_t e;
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (valid && rst) begin
        if (stall_M) begin
          cnt++;
          chk("regw_while_stalled", regw_M, 0);
        end else if (ret_q.size() == 0) begin
          n_vec++; errs++;
          $display("FAIL retire: DUT released an instruction, required none pending");
        end else begin
          e = ret_q.pop_front();
          chk("regw_M", regw_M, e.regw);
          chk("regmem_M", regmem_M, e.regmem);
          chk("regScr_M", regScr_M, e.scr);
          chk("ALUrslt_M", ALUrslt_M, e.alu);
          chk("readdata_M", readdata_M, e.rd);
          chk("stall_cycles", cnt, e.stalls);
          cnt = 0;
        end
      end
    end
  end

  initial begin
    logic [127:0] partial;
    int k;
    rst = 0; auto = 1; valid = 0; bail = 0; man_ack = 0; man_rdata = 0; exp_rd = '0;
    memrd_E = 0; memwr_E = 0; vec_E = 0; regw_E = 0; regmem_E = 0; regScr_E = 0;
    ALUrslt_E = '0; wdata_E = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall_M", stall_M, 0);
    chk("reset_mem_req", bus.mem_req, 0);
    chk("reset_mem_we", bus.mem_we, 0);
    chk("reset_readdata", readdata_M, 0);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      ref_mem[32'h100 + 32'(4 * i)] = 32'h11111111 * 32'(i + 1);
      bus_mem[32'h100 + 32'(4 * i)] = 32'h11111111 * 32'(i + 1);
    end
    ref_mem[32'h200] = 32'hCAFEF00D;
    bus_mem[32'h200] = 32'hCAFEF00D;
    issue(mk(1, 0, 1, 32'h100, '0, 16'h0000, 0));
    chk("vec_load_value", readdata_M, 128'h44444444_33333333_22222222_11111111);
    issue(mk(0, 1, 1, 32'h100, {{4{8'hDD}}, {4{8'hCC}}, {4{8'hBB}}, {4{8'hAA}}}, 16'h0020, 0));
    issue(mk(1, 0, 0, 32'h203, '0, 16'h0000, 0));
    chk("scalar_load_value", readdata_M, 128'hCAFEF00D);
    issue(mk(1, 0, 1, 32'h100, '0, 16'h0000, 3));
    issue(mk(0, 0, 0, 32'h40, '0, 16'h0000, 0));
    issue(mk(1, 0, 0, 32'h104, '0, 16'h0000, 0));
    issue(mk(0, 0, 1, 32'h44, '0, 16'h0000, 0));
    issue(mk(1, 0, 1, 32'hFFFFFFF8, '0, 16'h1201, 0));
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      k = int'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                      : 32'h1000 + 32'($urandom_range(0, 127));
      issue(mk(k == 1 || k == 3, k >= 2, 1'($urandom), a, {$urandom, $urandom, $urandom, $urandom},
               16'($urandom) & 16'h3333, int'($urandom_range(0, 2))));
    end
    if (!bail) begin
      auto = 0;
      memrd_E = 1; memwr_E = 0; vec_E = 1; regw_E = 1; ALUrslt_E = 128'h300;
      @(posedge clk); #1;
      man_ack = 1; man_rdata = 32'h12345678;
      @(posedge clk); #1;
      man_rdata = 32'h9ABCDEF0;
      @(posedge clk); #1;
      man_ack = 0;
      partial = {exp_rd[127:64], 32'h9ABCDEF0, 32'h12345678};
      chk("partial_readdata", readdata_M, partial);
      chk("beat2_mem_req", bus.mem_req, 1);
      rst = 0; memrd_E = 0;
      @(posedge clk); #1;
      chk("abort_mem_req", bus.mem_req, 0);
      chk("abort_stall_M", stall_M, 0);
      chk("abort_readdata", readdata_M, 0);
      rst = 1; man_ack = 1; man_rdata = 32'hFFFFFFFF;
      repeat (2) begin
        @(posedge clk); #1;
        chk("stray_ack_mem_req", bus.mem_req, 0);
        chk("stray_ack_stall_M", stall_M, 0);
        chk("stray_ack_readdata", readdata_M, 0);
      end
      man_ack = 0;
    end
    chk("beat_queue_drained", 128'(bq.size()), 0);
    chk("retire_queue_drained", 128'(ret_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
    $finish;
  end
endmodule
